// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the program sequencer.
//   state_e    : sequencer FSM states
//   start_addr : start address of a program index (index + 1)
package prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    RUN      = 3'd2,
    WAIT_LOW = 3'd3,
    FINISH   = 3'd4
  } state_e;

  // Native width of the address helper. The top casts the result to its own
  // address width. Any width >= 3 holds every start address (max 4).
  localparam int unsigned ADDR_W_DEF = 10;

  function automatic logic [ADDR_W_DEF-1:0] start_addr(input logic [1:0] idx);
    return ADDR_W_DEF'(idx) + ADDR_W_DEF'(1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Clearable, enabled, saturating up-counter with a terminal-count flag.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : force the count to zero next cycle (priority over en_i)
//   en_i           : count up by one per cycle, holding at all-ones
//   limit_i        : terminal value compared against the current count
//   count_o        : current count
//   term_o         : count_o == limit_i
//   sat_o          : count_o is all ones
module cycle_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         term_o,
  output logic         sat_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !sat_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = &count_q;
  assign term_o  = (count_q == limit_i);

endmodule

// File: rtl/prog_sequencer.sv
// Initiator side of the program-counter Start protocol. Launches programs
// 0..NUM_PROGS-1 in turn, holding Start for START_HOLD cycles, waits for the
// core's Done, records the RUN-cycle count per program and aborts a program
// that runs TIMEOUT cycles without Done.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset (forces IDLE)
//   go_i            : begin a sequence (sampled only in IDLE)
//   done_i          : core finished current program (level)
//   start_o         : launch strobe to the program counter
//   prog_idx_o      : index of the program being launched/run
//   start_addr_o    : start address of prog_idx_o
//   busy_o          : sequence in progress
//   prog_done_o     : one-cycle pulse per program completion
//   all_done_o      : sticky, every program completed
//   timeout_o       : sticky, a program exceeded TIMEOUT
//   last_cycles_o   : RUN-cycle count of the last completed program
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned L          = 10,
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CW         = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          go_i,
  input  logic          done_i,
  output logic          start_o,
  output logic [1:0]    prog_idx_o,
  output logic [L-1:0]  start_addr_o,
  output logic          busy_o,
  output logic          prog_done_o,
  output logic          all_done_o,
  output logic          timeout_o,
  output logic [CW-1:0] last_cycles_o
);

  localparam logic [CW-1:0] HOLD_LIM = CW'(START_HOLD - 1);
  localparam logic [CW-1:0] RUN_LIM  = CW'(TIMEOUT - 1);
  localparam logic [1:0]    LAST_IDX = 2'(NUM_PROGS - 1);

  state_e        state_q, state_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          prog_done_q, prog_done_d;
  logic          all_done_q, all_done_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    prog_idx_q, prog_idx_d;
  logic [L-1:0]  start_addr_q, start_addr_d;
  logic [CW-1:0] last_cycles_q, last_cycles_d;

  logic [CW-1:0] tmr_count, tmr_limit;
  logic          tmr_term, tmr_sat, tmr_clr;

  // One timer serves both the Start hold window and the RUN count. It is
  // held at zero outside LAUNCH/RUN and cleared on the last LAUNCH cycle so
  // that RUN always begins counting from zero.
  assign tmr_limit = (state_q == LAUNCH) ? HOLD_LIM : RUN_LIM;
  assign tmr_clr   = !((state_q == LAUNCH) || (state_q == RUN)) ||
                     ((state_q == LAUNCH) && tmr_term);

  cycle_timer #(.W(CW)) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (tmr_clr),
    .en_i    (1'b1),
    .limit_i (tmr_limit),
    .count_o (tmr_count),
    .term_o  (tmr_term),
    .sat_o   (tmr_sat)
  );

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    busy_d        = busy_q;
    prog_done_d   = 1'b0;
    all_done_d    = all_done_q;
    timeout_d     = timeout_q;
    prog_idx_d    = prog_idx_q;
    start_addr_d  = start_addr_q;
    last_cycles_d = last_cycles_q;
    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        busy_d  = 1'b0;
        if (go_i) begin
          all_done_d   = 1'b0;
          timeout_d    = 1'b0;
          prog_idx_d   = 2'd0;
          start_addr_d = L'(start_addr(2'd0));
          start_d      = 1'b1;
          busy_d       = 1'b1;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        // Done is deliberately not looked at while Start is asserted.
        if (tmr_term) begin
          start_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Done has priority over a timeout falling in the same cycle.
        if (done_i) begin
          prog_done_d   = 1'b1;
          last_cycles_d = tmr_sat ? tmr_count : tmr_count + CW'(1);
          state_d       = (prog_idx_q == LAST_IDX) ? FINISH : WAIT_LOW;
        end else if (tmr_term) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      WAIT_LOW: begin
        // A Done left high would otherwise be mistaken for the next
        // program's completion, so the next launch waits for it to drop.
        if (!done_i) begin
          prog_idx_d   = prog_idx_q + 2'd1;
          start_addr_d = L'(start_addr(prog_idx_q + 2'd1));
          start_d      = 1'b1;
          state_d      = LAUNCH;
        end
      end
      FINISH: begin
        all_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      prog_done_q   <= 1'b0;
      all_done_q    <= 1'b0;
      timeout_q     <= 1'b0;
      prog_idx_q    <= 2'd0;
      start_addr_q  <= '0;
      last_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      prog_done_q   <= prog_done_d;
      all_done_q    <= all_done_d;
      timeout_q     <= timeout_d;
      prog_idx_q    <= prog_idx_d;
      start_addr_q  <= start_addr_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign prog_done_o   = prog_done_q;
  assign all_done_o    = all_done_q;
  assign timeout_o     = timeout_q;
  assign prog_idx_o    = prog_idx_q;
  assign start_addr_o  = start_addr_q;
  assign last_cycles_o = last_cycles_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: a table of sequence vectors driven
// through one task, with launch and completion expectations queued as the
// stimulus is driven and checked by a monitor when the DUT produces them,
// plus hand-written reset and restart sequences.
module tb_prog_sequencer;

  localparam int L  = 10;
  localparam int NP = 3;
  localparam int SH = 2;
  localparam int TO = 1024;
  localparam int CW = 16;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          done = 1'b0;
  logic          start, busy, prog_done, all_done, timeout;
  logic [1:0]    prog_idx;
  logic [L-1:0]  start_addr;
  logic [CW-1:0] last_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_sequencer #(
    .L(L), .NUM_PROGS(NP), .START_HOLD(SH), .TIMEOUT(TO), .CW(CW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .go_i          (go),
    .done_i        (done),
    .start_o       (start),
    .prog_idx_o    (prog_idx),
    .start_addr_o  (start_addr),
    .busy_o        (busy),
    .prog_done_o   (prog_done),
    .all_done_o    (all_done),
    .timeout_o     (timeout),
    .last_cycles_o (last_cycles)
  );

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t launch_q[$];
  exp_t pd_q[$];

  typedef struct {
    int d0, d1, d2;     // RUN cycles with Done low before Done rises; -1 = never
    bit launch_done;    // drive Done high while Start is high
    int stuck;          // extra cycles Done stays high after ProgDone
    bit go_noise;       // toggle Go randomly during RUN
    bit no_go;          // sequence already launched by the previous vector
    bit hold_go;        // hold Go across FINISH to restart at once
    bit exp_all;
    bit exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic vec_t mk(input int d0, input int d1, input int d2,
                              input bit ld, input int st, input bit gn,
                              input bit ng, input bit hg, input bit ea, input bit et);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.launch_done = ld; v.stuck = st; v.go_noise = gn;
    v.no_go = ng; v.hold_go = hg; v.exp_all = ea; v.exp_to = et;
    return v;
  endfunction

  // Monitor: pops expectations when the DUT launches or completes a program.
  initial begin
    logic start_prev;
    int   hi_cnt;
    exp_t e;
    start_prev = 1'b0;
    hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        start_prev = 1'b0;
        hi_cnt = 0;
      end else begin
        if (start && !start_prev) begin
          check("launch_expected", launch_q.size() > 0, 1);
          if (launch_q.size() > 0) begin
            e = launch_q.pop_front();
            check("launch_idx", prog_idx, e.idx);
            check("launch_addr", start_addr, e.val);
            check("launch_busy", busy, 1);
          end
        end
        if (start) begin
          hi_cnt++;
        end else if (start_prev) begin
          check("start_width", hi_cnt, SH);
          hi_cnt = 0;
        end
        if (prog_done) begin
          check("progdone_expected", pd_q.size() > 0, 1);
          if (pd_q.size() > 0) begin
            e = pd_q.pop_front();
            check("progdone_idx", prog_idx, e.idx);
            check("last_cycles", last_cycles, e.val);
          end
        end
        start_prev = start;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_prog_idx"}, prog_idx, 0);
    check({tag, "_start_addr"}, start_addr, 0);
    check({tag, "_prog_done"}, prog_done, 0);
    check({tag, "_all_done"}, all_done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_last_cycles"}, last_cycles, 0);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_start_high();
    int n;
    n = 0;
    while (!start && n < 50) begin @(negedge clk); n++; end
    check("start_seen", start, 1);
  endtask

  task automatic wait_start_low();
    int n;
    n = 0;
    while (start && n < 50) begin @(negedge clk); n++; end
    check("start_dropped", start, 0);
  endtask

  task automatic run_seq(input vec_t v);
    int n;
    int dl[3];
    bit aborted;
    int exp_lc;
    dl[0] = v.d0; dl[1] = v.d1; dl[2] = v.d2;
    aborted = 1'b0;
    if (!v.no_go) begin
      launch_q.push_back('{0, 1});
      pulse_go();
      check("go_all_done_clr", all_done, 0);
      check("go_timeout_clr", timeout, 0);
      check("go_busy", busy, 1);
    end
    for (int p = 0; p < NP && !aborted; p++) begin
      wait_start_high();
      if (v.launch_done) done = 1'b1;
      wait_start_low();
      done = 1'b0;            // now in the first RUN cycle (count 0)
      if (dl[p] < 0) begin
        n = 0;
        while (!timeout && n < TO + 20) begin
          if (v.go_noise) go = 1'($urandom_range(0, 1));
          @(negedge clk);
          n++;
        end
        go = 1'b0;
        check("timeout_cycles", n, TO);
        check("timeout_busy", busy, 0);
        check("timeout_no_progdone", prog_done, 0);
        aborted = 1'b1;
      end else begin
        for (int c = 0; c < dl[p]; c++) begin
          if (v.go_noise) go = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        go = 1'b0;
        done = 1'b1;
        exp_lc = (dl[p] + 1 > SAT) ? SAT : dl[p] + 1;
        pd_q.push_back('{p, exp_lc});
        n = 0;
        do begin @(negedge clk); n++; end while (!prog_done && n < 20);
        check("progdone_latency", n, 1);
        if (p < NP - 1) begin
          for (int s = 0; s < v.stuck; s++) begin
            check("stall_no_start", start, 0);
            check("stall_busy", busy, 1);
            @(negedge clk);
          end
          launch_q.push_back('{p + 1, p + 2});
          done = 1'b0;
        end else begin
          done = 1'b0;
          if (v.hold_go) begin
            go = 1'b1;
            @(negedge clk);
            check("gap_busy", busy, 0);
            check("gap_all_done", all_done, 1);
            launch_q.push_back('{0, 1});
            @(negedge clk);
            go = 1'b0;
            check("restart_start", start, 1);
            check("restart_all_done_clr", all_done, 0);
          end
        end
      end
    end
    if (!v.hold_go) begin
      n = 0;
      while (busy && n < 50) begin @(negedge clk); n++; end
      check("end_busy", busy, 0);
      check("end_all_done", all_done, v.exp_all);
      check("end_timeout", timeout, v.exp_to);
      check("end_start", start, 0);
      check("launch_q_empty", launch_q.size(), 0);
      check("pd_q_empty", pd_q.size(), 0);
    end
  endtask

  initial begin
    //               d0  d1  d2    ld st gn ng hg all to
    vecs[0] = mk(    5,  5,  5,    0, 0, 0, 0, 0, 1, 0);
    vecs[1] = mk(    0,  3,  7,    1, 3, 0, 0, 0, 1, 0);
    vecs[2] = mk(    5, -1,  0,    0, 0, 1, 0, 0, 0, 1);
    vecs[3] = mk(    2,  1, TO-1,  0, 0, 0, 0, 0, 1, 0);
    vecs[4] = mk(    4,  2,  6,    0, 0, 0, 0, 1, 1, 0);
    vecs[5] = mk(    1,  1,  1,    0, 0, 0, 1, 0, 1, 0);
    vecs[6] = mk(int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
                 int'($urandom_range(0, 30)), 1, 1, 1, 0, 0, 1, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 7; i++) begin
      run_seq(vecs[i]);
    end

    // Reset in RUN of program 1 aborts; Go then restarts at program 0.
    launch_q.push_back('{0, 1});
    pulse_go();
    wait_start_high();
    wait_start_low();
    repeat (3) @(negedge clk);
    done = 1'b1;
    pd_q.push_back('{0, 4});
    @(negedge clk);
    done = 1'b0;
    launch_q.push_back('{1, 2});
    wait_start_high();
    wait_start_low();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrun_reset");
    reset = 1'b0;
    check("midrun_queues", launch_q.size() + pd_q.size(), 0);
    run_seq(mk(3, 0, 2, 0, 0, 0, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
